lsu_pipe: RTL and testbench
===========================

Name: lsu_pipe

Overview:
- Parametrised load/store unit for the MEM stage of the 5-stage LoongArch pipeline. It replaces the single-cycle, fixed-latency, read-modify-write data SRAM access.
- Talks to a data memory that has a request/grant handshake, variable latency and byte-enables. Up to MAX_OUTST requests may be in flight, with in-order responses.
- Does sub-word load extraction with sign/zero extension and store lane placement, supports pipeline flush, and drives a stall signal back to the hazard logic.

Parameters:
- ADDR_W, 32, address width.
- MAX_OUTST, 2, maximum number of accepted but not yet responded requests. Power of 2, range 1..8.
- DEST_W, 5, width of the destination register tag.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  MEM stage presents an access.
- req_ready  out  1  access accepted this cycle.
- req_load_op  in  5  one-hot: [0] ld.w, [1] ld.h, [2] ld.b, [3] ld.hu, [4] ld.bu.
- req_store_op  in  3  one-hot: [0] st.w, [1] st.h, [2] st.b.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_dest  in  DEST_W  load destination register.
- flush  in  1  kill all in-flight responses.
- stall  out  1  equals req_valid & ~req_ready.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory grant.
- mem_addr  out  ADDR_W  word address; bits [1:0] are forced to 0.
- mem_we  out  1  write.
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  lane-placed store data.
- mem_rvalid  in  1  in-order response, one per granted request (loads and stores).
- mem_rdata  in  32  read word.
- resp_valid  out  1  result available.
- resp_we  out  1  response is a load (register write).
- resp_dest  out  DEST_W  destination tag.
- resp_data  out  32  extended load data.
- resp_ale  out  1  misaligned access (feature only; tied 0 otherwise).
- err_spurious  out  1  sticky flag: mem_rvalid arrived with no entry outstanding.

Behaviour:
- Reset, asynchronous: FIFO emptied, count=0, resp_valid=0, resp_we=0, resp_dest=0, resp_data=0, resp_ale=0, err_spurious=0.
- A request is a load if req_load_op≠0 and a store if req_store_op≠0. req_valid with both fields zero is illegal; the verification assertion flags it.
- mem_req = req_valid & ~full & ~flush.
- req_ready = mem_req & mem_gnt.
- full means count==MAX_OUTST, using the registered count. A pop in the same cycle does not free a slot for that cycle.
- Store lane placement, with off=req_addr[1:0]:
  - st.b: wstrb=1<<off; byte replicated on all 4 lanes.
  - st.h: wstrb=off[1]?4'b1100:4'b0011; half replicated on both halves.
  - st.w: wstrb=4'b1111.
  - For loads, wstrb=0.
- On acceptance, push {is_load, load_op, off, dest, kill=0} into the FIFO. Count changes +1 on push, -1 on pop, net 0 when both happen.
- On mem_rvalid with FIFO non-empty, pop the head. One cycle later:
  - resp_valid=1 unless the head's kill bit was set.
  - resp_we=is_load, resp_dest=dest.
  - resp_data = mem_rdata shifted right by 8*off, then extended per load_op. For stores, resp_data=0.
  - ld.h/ld.hu with off=1 or 3 use only the byte lanes available after the shift; upper bits are zero before extension.
- Load-use latency is 1 cycle after mem_rvalid. resp_valid is a single-cycle pulse with no backpressure; WB always accepts it.
- mem_rvalid with the FIFO empty is dropped and sets err_spurious, which stays set until reset.
- flush: sets the kill bit on every valid entry in the same cycle. Responses to those entries are still popped but produce no resp_valid. No acceptance happens in a flush cycle.
- flush and mem_rvalid in the same cycle: the popped entry is suppressed.
- Entries stay ordered across count wrap-around; pointers are log2(MAX_OUTST) bits with modulo wrap.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A request is misaligned if it is ld.w/st.w with off≠0, or a half-word access with off[0]=1.
  - A misaligned request raises no mem_req. It is accepted only when count==0 and no response is pending.
  - The next cycle gives resp_valid=1, resp_ale=1, resp_we=0, resp_data=0.
- Undefined: no alignment check; word accesses ignore off for lane placement; resp_ale is tied 0.

Decomposition:
- Package lsu_pkg holds:
  - LD_W/LD_H/LD_B/LD_HU/LD_BU and ST_W/ST_H/ST_B bit-index constants;
  - the FIFO entry struct type;
  - the wstrb lookup function.
- Sub-module lsu_meta_fifo holds the parametrised MAX_OUTST-deep metadata FIFO. It has push, pop, flush-kill, full/empty and count outputs.

Test Plan:
- st.b addr=0x1c000003 wdata=0xAB -> mem_wstrb=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x1c000000, req_ready in the grant cycle.
- ld.b off=2, mem_rdata=0x00800000 -> resp_data=0xFFFFFF80 one cycle after mem_rvalid; the same case as ld.bu gives 0x00000080.
- MAX_OUTST=2:
  - three back-to-back loads, gnt always 1, rvalid delayed 4 cycles -> third load stalls (stall=1) until the cycle after the first pop;
  - responses arrive in issue order.
- Two loads outstanding, flush asserted -> both responses produce no resp_valid; a load issued after the flush returns normally.
- mem_rvalid with count=0 -> err_spurious=1, held until resetn=0.
- Macro defined, ld.w addr=0x...2 -> no mem_req, resp_ale=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: op bit indices, FIFO metadata entry and store strobe lookup
// shared by the LoongArch MEM-stage load/store unit.
package lsu_pkg;

  localparam int LD_W  = 0;
  localparam int LD_H  = 1;
  localparam int LD_B  = 2;
  localparam int LD_HU = 3;
  localparam int LD_BU = 4;

  localparam int ST_W = 0;
  localparam int ST_H = 1;
  localparam int ST_B = 2;

  // dest tag is kept beside this entry so its width can follow DEST_W
  typedef struct packed {
    logic       is_load;
    logic [4:0] load_op;
    logic [1:0] off;
    logic       kill;
  } meta_t;

  function automatic logic [3:0] wstrb_f(
    input logic [2:0] sop,
    input logic [1:0] off
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      sop[ST_B]: s = 4'b0001 << off;
      sop[ST_H]: s = off[1] ? 4'b1100 : 4'b0011;
      sop[ST_W]: s = 4'b1111;
      default:   s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_meta_fifo.sv
// lsu_meta_fifo: DEPTH-entry in-order metadata FIFO for outstanding
// memory requests, with a flush that marks every held entry as killed.
module lsu_meta_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 5,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  meta_t             push_meta_i,
  input  logic [DEST_W-1:0] push_dest_i,
  input  logic              pop_i,
  input  logic              kill_i,
  output meta_t             head_meta_o,
  output logic [DEST_W-1:0] head_dest_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  meta_t             meta_q [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              push_eff;
  logic              pop_eff;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign count_o  = cnt_q;
  assign push_eff = push_i & ~full_o;
  assign pop_eff  = pop_i & ~empty_o;

  assign head_meta_o = meta_q[rd_q];
  assign head_dest_o = dest_q[rd_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      // stale slots get killed too; a later push overwrites them
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          meta_q[i].kill <= 1'b1;
        end
      end
      if (push_eff) begin
        meta_q[wr_q] <= push_meta_i;
        dest_q[wr_q] <= push_dest_i;
        wr_q         <= inc(wr_q);
      end
      if (pop_eff) begin
        rd_q <= inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: MEM-stage load/store unit, req/gnt memory port, in-order responses.
// Optional misaligned-access trap when LSU_ALIGN_CHECK_EN is defined.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int DEST_W    = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_load_op,
  input  logic [2:0]        req_store_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [DEST_W-1:0] req_dest,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [DEST_W-1:0] resp_dest,
  output logic [31:0]       resp_data,
  output logic              resp_ale,
  output logic              err_spurious
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  meta_t             head_meta;
  meta_t             push_meta;
  logic [DEST_W-1:0] head_dest;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              is_load;
  logic              is_store;
  logic              push;
  logic              pop;
  logic              mis;
  logic              ale_acc;
  logic [1:0]        off;
  logic [31:0]       sh;
  logic [31:0]       ext;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_we_q, resp_we_d;
  logic              resp_ale_q, resp_ale_d;
  logic [DEST_W-1:0] resp_dest_q, resp_dest_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              err_q, err_d;

  assign off      = req_addr[1:0];
  assign is_load  = |req_load_op;
  assign is_store = |req_store_op;

`ifdef LSU_ALIGN_CHECK_EN
  assign mis = ((req_load_op[LD_W] | req_store_op[ST_W]) & (off != 2'b00))
             | ((req_load_op[LD_H] | req_load_op[LD_HU]
               | req_store_op[ST_H]) & off[0]);
  // trap only with nothing in flight, so its response slot is free
  assign ale_acc = req_valid & mis & ~flush
                 & (count == '0) & ~mem_rvalid;
`else
  logic unused_cnt;
  assign unused_cnt = ^count;
  assign mis        = 1'b0;
  assign ale_acc    = 1'b0;
`endif

  assign mem_req   = req_valid & ~full & ~flush & ~mis;
  assign push      = mem_req & mem_gnt;
  assign req_ready = push | ale_acc;
  assign stall     = req_valid & ~req_ready;
  assign pop       = mem_rvalid & ~empty;

  assign mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem_we    = is_store;
  assign mem_wstrb = wstrb_f(req_store_op, off);

  always_comb begin
    mem_wdata = req_wdata;
    unique case (1'b1)
      req_store_op[ST_B]: mem_wdata = {4{req_wdata[7:0]}};
      req_store_op[ST_H]: mem_wdata = {2{req_wdata[15:0]}};
      default:            mem_wdata = req_wdata;
    endcase
  end

  assign push_meta = '{
    is_load: is_load,
    load_op: req_load_op,
    off:     off,
    kill:    1'b0
  };

  lsu_meta_fifo #(
    .DEPTH  (MAX_OUTST),
    .DEST_W (DEST_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_meta_i (push_meta),
    .push_dest_i (req_dest),
    .pop_i       (pop),
    .kill_i      (flush),
    .head_meta_o (head_meta),
    .head_dest_o (head_dest),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  // sub-word lanes land at bit 0; short halves see zeros above
  assign sh = mem_rdata >> {head_meta.off, 3'b000};

  always_comb begin
    ext = '0;
    unique case (1'b1)
      head_meta.load_op[LD_W]:  ext = mem_rdata;
      head_meta.load_op[LD_H]:  ext = {{16{sh[15]}}, sh[15:0]};
      head_meta.load_op[LD_B]:  ext = {{24{sh[7]}}, sh[7:0]};
      head_meta.load_op[LD_HU]: ext = {16'h0000, sh[15:0]};
      head_meta.load_op[LD_BU]: ext = {24'h000000, sh[7:0]};
      default:                  ext = '0;
    endcase
  end

  always_comb begin
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_ale_d   = 1'b0;
    resp_dest_d  = resp_dest_q;
    resp_data_d  = resp_data_q;
    err_d        = err_q | (mem_rvalid & empty);
    if (pop) begin
      resp_valid_d = ~(head_meta.kill | flush);
      resp_we_d    = head_meta.is_load;
      resp_dest_d  = head_dest;
      resp_data_d  = head_meta.is_load ? ext : '0;
    end else if (ale_acc) begin
      resp_valid_d = 1'b1;
      resp_ale_d   = 1'b1;
      resp_dest_d  = req_dest;
      resp_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_ale_q   <= 1'b0;
      resp_dest_q  <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_ale_q   <= resp_ale_d;
      resp_dest_q  <= resp_dest_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_we      = resp_we_q;
  assign resp_ale     = resp_ale_q;
  assign resp_dest    = resp_dest_q;
  assign resp_data    = resp_data_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed scenarios plus a randomized run checked against
// a queue-based reference model of the load/store unit.
`timescale 1ns/1ps
module tb_lsu_pipe;

  localparam int ADDR_W    = 32;
  localparam int MAX_OUTST = 2;
  localparam int DEST_W    = 5;

  logic              clk;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_load_op;
  logic [2:0]        req_store_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [DEST_W-1:0] req_dest;
  logic              flush;
  logic              stall;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic              resp_we;
  logic [DEST_W-1:0] resp_dest;
  logic [31:0]       resp_data;
  logic              resp_ale;
  logic              err_spurious;

  lsu_pipe #(
    .ADDR_W    (ADDR_W),
    .MAX_OUTST (MAX_OUTST),
    .DEST_W    (DEST_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_load_op  (req_load_op),
    .req_store_op (req_store_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_dest     (req_dest),
    .flush        (flush),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_we      (resp_we),
    .resp_dest    (resp_dest),
    .resp_data    (resp_data),
    .resp_ale     (resp_ale),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_load;
    int op;
    int off;
    int dest;
    bit kill;
  } ent_t;

  ent_t outst[$];
  int   pend[$];

  always @(negedge clk)
    if (resetn && req_valid)
      assert ((req_load_op != 0) != (req_store_op != 0))
        else $error("illegal request op encoding");

  function automatic logic [31:0] ref_load(int op, int off, logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] h;
    logic [31:0] b;
    v = rd >> (8 * off);
    h = v % 32'd65536;
    b = v % 32'd256;
    case (op)
      0: return rd;
      1: return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      2: return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3: return h;
      4: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(bit ld, int op, int off);
    if (ld) return 4'h0;
    if (op == 2) return 4'(1 << off);
    if (op == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(int op, logic [31:0] w);
    if (op == 2) return (w % 32'd256) * 32'h01010101;
    if (op == 1) return (w % 32'd65536) * 32'h00010001;
    return w;
  endfunction

  task automatic drive_req(input bit v, input bit ld, input int op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int d);
    req_valid    = v;
    req_load_op  = ld ? 5'(1 << op) : 5'd0;
    req_store_op = ld ? 3'd0 : 3'(1 << op);
    req_addr     = a;
    req_wdata    = wd;
    req_dest     = DEST_W'(d);
  endtask

  task automatic idle_req();
    req_valid    = 1'b0;
    req_load_op  = '0;
    req_store_op = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_dest     = '0;
  endtask

  task automatic test_reset();
    idle_req();
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    resetn     = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_we !== 1'b0 || resp_ale !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got v=%b we=%b ale=%b exp 0 0 0",
               resp_valid, resp_we, resp_ale);
    end
    checks++;
    if (resp_dest !== '0 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got dest=%0d data=%h exp 0",
               resp_dest, resp_data);
    end
    checks++;
    if (err_spurious !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_misc got err=%b req=%b stall=%b exp 0",
               err_spurious, mem_req, stall);
    end
    resetn = 1'b1;
    @(negedge clk);
    outst.delete();
    pend.delete();
  endtask

  task automatic test_store_lane();
    @(negedge clk);
    drive_req(1, 0, 2, 32'h1c000003, 32'h000000AB, 0);
    mem_gnt = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b1000) begin
      failures++;
      $display("FAIL stb_ctrl got rdy=%b we=%b strb=%b exp 1 1 1000",
               req_ready, mem_we, mem_wstrb);
    end
    checks++;
    if (mem_wdata !== 32'hABABABAB || mem_addr !== 32'h1c000000) begin
      failures++;
      $display("FAIL stb_data got wd=%h a=%h exp ABABABAB 1c000000",
               mem_wdata, mem_addr);
    end
    @(negedge clk);
    drive_req(1, 0, 1, 32'h1c000012, 32'h55661234, 0);
    #1;
    checks++;
    if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h12341234) begin
      failures++;
      $display("FAIL sth_lane got strb=%b wd=%h exp 1100 12341234",
               mem_wstrb, mem_wdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_we !== 1'b0 || resp_data !== 32'd0) begin
          failures++;
          $display("FAIL st_resp0 got v=%b we=%b d=%h exp 1 0 0",
                   resp_valid, resp_we, resp_data);
        end
      end
      idle_req();
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_we !== 1'b0 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL st_resp1 got v=%b we=%b d=%h exp 1 0 0",
               resp_valid, resp_we, resp_data);
    end
  endtask

  task automatic test_load_ext();
    int          ops [3] = '{2, 4, 1};
    int          offs[3] = '{2, 2, 3};
    logic [31:0] rds [3] = '{32'h00800000, 32'h00800000, 32'h80123456};
    logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080};
    int          n;
`ifdef LSU_ALIGN_CHECK_EN
    n = 2;
`else
    n = 3;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_req(1, 1, ops[i], 32'h1c000000 + 32'(offs[i]), 0, 3 + i);
      mem_gnt = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL ldx_rdy%0d got %b exp 1", i, req_ready);
      end
      @(negedge clk);
      idle_req();
      mem_rvalid = 1'b1;
      mem_rdata  = rds[i];
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_we !== 1'b1 ||
          resp_dest !== DEST_W'(3 + i) || resp_data !== exps[i]) begin
        failures++;
        $display("FAIL ldx%0d got v=%b we=%b dst=%0d d=%h exp d=%h",
                 i, resp_valid, resp_we, resp_dest, resp_data, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          q_dest[$];
    int          q_t[$];
    logic [31:0] q_d[$];
    logic [31:0] exp_data;
    int          exp_dest;
    bit          exp_v;
    int          issued;
    int          occ;
    bit          acc;
    int          t3;
    issued = 0;
    exp_v  = 0;
    t3     = -1;
    exp_dest = 0;
    exp_data = '0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (exp_v) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_dest !== DEST_W'(exp_dest) ||
            resp_data !== exp_data) begin
          failures++;
          $display("FAIL b2b_resp t=%0d got v=%b dst=%0d d=%h exp dst=%0d d=%h",
                   t, resp_valid, resp_dest, resp_data, exp_dest, exp_data);
        end
      end
      exp_v      = 0;
      occ        = q_dest.size();
      mem_rvalid = (q_t.size() > 0) && (q_t[0] == t);
      mem_rdata  = $urandom;
      if (mem_rvalid) begin
        void'(q_t.pop_front());
        exp_dest = q_dest.pop_front();
        exp_data = mem_rdata;
        exp_v    = 1;
      end
      if (issued < 3)
        drive_req(1, 1, 0, 32'h1c000100 + 32'(4 * issued), 0, issued + 1);
      else
        idle_req();
      mem_gnt = 1'b1;
      #1;
      acc = (issued < 3) && (occ < MAX_OUTST);
      checks++;
      if (req_ready !== acc || stall !== (issued < 3 && !acc)) begin
        failures++;
        $display("FAIL b2b_hs t=%0d got rdy=%b stall=%b exp rdy=%b",
                 t, req_ready, stall, acc);
      end
      if (acc) begin
        q_dest.push_back(issued + 1);
        q_t.push_back(t + 4);
        if (issued == 2) t3 = t;
        issued++;
      end
    end
    checks++;
    if (t3 != 5) begin
      failures++;
      $display("FAIL b2b_third_accept got t=%0d exp 5", t3);
    end
    idle_req();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_req(1, 1, 0, 32'h1c000200 + 32'(4 * i), 0, 7 + i);
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL fl_issue%0d got %b exp 1", i, req_ready);
      end
    end
    @(negedge clk);
    drive_req(1, 1, 0, 32'h1c000300, 0, 20);
    flush = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL fl_block got req=%b rdy=%b stall=%b exp 0 0 1",
               mem_req, req_ready, stall);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (resp_valid !== 1'b0) begin
          failures++;
          $display("FAIL fl_kill0 got v=%b exp 0", resp_valid);
        end
      end
      flush = 1'b0;
      idle_req();
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL fl_kill1 got v=%b exp 0", resp_valid);
    end
    mem_rvalid = 1'b0;
    drive_req(1, 1, 3, 32'h1c000402, 0, 9);
    @(negedge clk);
    idle_req();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF1234;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_we !== 1'b1 ||
        resp_dest !== DEST_W'(9) || resp_data !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL fl_after got v=%b we=%b dst=%0d d=%h exp 1 1 9 0000beef",
               resp_valid, resp_we, resp_dest, resp_data);
    end
    drive_req(1, 1, 2, 32'h1c000500, 0, 10);
    @(negedge clk);
    idle_req();
    mem_rvalid = 1'b1;
    flush      = 1'b1;
    mem_rdata  = 32'h000000FF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL fl_same_cycle got v=%b err=%b exp 0 0",
               resp_valid, err_spurious);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    idle_req();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL spur_set got err=%b v=%b exp 1 0",
               err_spurious, resp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spur_hold got %b exp 1", err_spurious);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL spur_clear got %b exp 0", err_spurious);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

`ifdef LSU_ALIGN_CHECK_EN
  task automatic test_align();
    @(negedge clk);
    drive_req(1, 1, 0, 32'h1c000600, 0, 4);
    mem_gnt = 1'b1;
    @(negedge clk);
    drive_req(1, 1, 0, 32'h1c000602, 0, 5);
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL ale_busy got req=%b rdy=%b stall=%b exp 0 0 1",
               mem_req, req_ready, stall);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ale_acc got req=%b rdy=%b exp 0 1", mem_req, req_ready);
    end
    @(negedge clk);
    idle_req();
    checks++;
    if (resp_valid !== 1'b1 || resp_ale !== 1'b1 ||
        resp_we !== 1'b0 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL ale_resp got v=%b ale=%b we=%b d=%h exp 1 1 0 0",
               resp_valid, resp_ale, resp_we, resp_data);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    bit          cur_v;
    bit          cur_ld;
    int          cur_op;
    int          cur_off;
    int          cur_dest;
    logic [31:0] cur_addr;
    logic [31:0] cur_wd;
    logic [31:0] tmp;
    bit          exp_v;
    bit          exp_we;
    int          exp_dest;
    logic [31:0] exp_data;
    bit          exp_req;
    bit          exp_rdy;
    int          occ;
    ent_t        e;
    localparam int N = 600;
    cur_v = 0;
    exp_v = 0;
    cur_ld = 0; cur_op = 0; cur_off = 0; cur_dest = 0;
    cur_addr = '0; cur_wd = '0;
    exp_we = 0; exp_dest = 0; exp_data = '0;
    for (int t = 0; t < N + 200; t++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== exp_v) begin
        failures++;
        $display("FAIL rnd_valid t=%0d got %b exp %b", t, resp_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (resp_we !== exp_we || resp_dest !== DEST_W'(exp_dest) ||
            resp_data !== exp_data || resp_ale !== 1'b0) begin
          failures++;
          $display("FAIL rnd_resp t=%0d got we=%b dst=%0d d=%h exp we=%b dst=%0d d=%h",
                   t, resp_we, resp_dest, resp_data, exp_we, exp_dest, exp_data);
        end
      end
      if (t >= N && outst.size() == 0 && !cur_v) break;
      if (!cur_v && t < N && ($urandom % 4) != 0) begin
        cur_v   = 1;
        cur_ld  = ($urandom % 2) == 1;
        cur_op  = cur_ld ? int'($urandom % 5) : int'($urandom % 3);
        cur_off = int'($urandom % 4);
        if (cur_op == 0) cur_off = 0;
`ifdef LSU_ALIGN_CHECK_EN
        if ((cur_ld && (cur_op == 1 || cur_op == 3)) || (!cur_ld && cur_op == 1))
          cur_off = cur_off & 2;
`endif
        tmp      = $urandom;
        cur_addr = {tmp[31:2], 2'(cur_off)};
        cur_wd   = $urandom;
        cur_dest = int'($urandom_range(0, 31));
      end
      drive_req(cur_v, cur_ld, cur_op, cur_addr, cur_wd, cur_dest);
      mem_gnt    = ($urandom % 4) != 0;
      flush      = (t < N) && (($urandom % 20) == 0);
      occ        = outst.size();
      mem_rvalid = (pend.size() > 0) && (pend[0] <= t) && (($urandom % 3) != 0);
      mem_rdata  = $urandom;
      #1;
      exp_req = cur_v && (occ < MAX_OUTST) && !flush;
      exp_rdy = exp_req && mem_gnt;
      checks++;
      if (mem_req !== exp_req || req_ready !== exp_rdy ||
          stall !== (cur_v && !exp_rdy)) begin
        failures++;
        $display("FAIL rnd_hs t=%0d got req=%b rdy=%b stall=%b exp req=%b rdy=%b",
                 t, mem_req, req_ready, stall, exp_req, exp_rdy);
      end
      if (exp_req) begin
        checks++;
        if (mem_addr !== (cur_addr & 32'hFFFFFFFC) || mem_we !== !cur_ld ||
            mem_wstrb !== ref_strb(cur_ld, cur_op, cur_off) ||
            (!cur_ld && mem_wdata !== ref_wdata(cur_op, cur_wd))) begin
          failures++;
          $display("FAIL rnd_mem t=%0d got a=%h we=%b strb=%b wd=%h",
                   t, mem_addr, mem_we, mem_wstrb, mem_wdata);
        end
      end
      exp_v = 0;
      if (mem_rvalid) begin
        e = outst.pop_front();
        void'(pend.pop_front());
        exp_v    = !(e.kill || flush);
        exp_we   = e.is_load;
        exp_dest = e.dest;
        exp_data = e.is_load ? ref_load(e.op, e.off, mem_rdata) : 32'd0;
      end
      if (flush) begin
        foreach (outst[i]) outst[i].kill = 1'b1;
      end
      if (exp_rdy) begin
        e.is_load = cur_ld;
        e.op      = cur_op;
        e.off     = cur_off;
        e.dest    = cur_dest;
        e.kill    = 1'b0;
        outst.push_back(e);
        pend.push_back(t + 1 + int'($urandom % 5));
        cur_v = 0;
      end
    end
    checks++;
    if (outst.size() != 0 || cur_v) begin
      failures++;
      $display("FAIL rnd_drain got outst=%0d pending_req=%b exp 0 0",
               outst.size(), cur_v);
    end
    idle_req();
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL rnd_err got %b exp 0", err_spurious);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_lane();
    test_load_ext();
    test_back_to_back();
    test_flush();
    test_spurious();
`ifdef LSU_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
